// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types for the operand forwarding / hazard stage.
//   fwd_sel_t   - which producer supplied an operand (RF, WB, MEM, EX)
//   fwd_state_t - stall tracking FSM state
package fwd_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } fwd_sel_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fwd_state_t;

endpackage

// File: rtl/fwd_src_select.sv
// fwd_src_select: combinational producer select for one source operand.
// Picks the youngest in-flight writer of the source register (EX > MEM > WB),
// falling back to the register-file value. Flags a hazard when the winning
// producer has not finished computing its result yet.
//   idx/used/rf_data         - source register index, read enable, RF data
//   {ex,mem,wb}_we/dest/data - stage writeback buses
//   ex_ok/mem_ok             - stage result valid this cycle (WB always valid)
//   data/sel/hazard          - selected operand, its source, not-ready flag
module fwd_src_select
  import fwd_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int OW     = 32
) (
  input  logic [REG_AW-1:0] idx,
  input  logic              used,
  input  logic [OW-1:0]     rf_data,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_ok,
  input  logic [OW-1:0]     ex_data,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_ok,
  input  logic [OW-1:0]     mem_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [OW-1:0]     wb_data,
  output logic [OW-1:0]     data,
  output fwd_sel_t          sel,
  output logic              hazard
);

  // Register 0 is hard zero: never forwarded, never a hazard.
  logic live, ex_hit, mem_hit, wb_hit;
  assign live    = used && (idx != '0);
  assign ex_hit  = live && ex_we  && (ex_dest  == idx);
  assign mem_hit = live && mem_we && (mem_dest == idx);
  assign wb_hit  = live && wb_we  && (wb_dest  == idx);

  always_comb begin
    data   = rf_data;
    sel    = FWD_RF;
    hazard = 1'b0;
    if (ex_hit) begin
      data   = ex_data;
      sel    = FWD_EX;
      hazard = !ex_ok;
    end else if (mem_hit) begin
      data   = mem_data;
      sel    = FWD_MEM;
      hazard = !mem_ok;
    end else if (wb_hit) begin
      data   = wb_data;
      sel    = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: ID->EX operand forwarding and hazard stall stage.
// Each of NSRC sources gets the youngest in-flight producer value; ID is
// stalled while a selected producer is not ready. Operands are registered
// into the ID/EX register (one cycle latency), with a saturating total stall
// counter and a sticky flag raised when one stall run reaches MAX_STALL.
//   clk/rst                      - clock, synchronous active-high reset
//   id_valid/id_src_*            - instruction in ID and its source operands
//   {ex,mem,wb}_*                - stage writeback buses, ex_ok/mem_ok ready
//   flush                        - kill the instruction entering EX
//   stall                        - combinational freeze of IF/ID
//   op_valid/op_data/op_sel      - registered EX operands and their sources
//   stall_cycles/stall_timeout   - stall statistics
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int LANES     = 1,
  parameter int REG_AW    = 4,
  parameter int NSRC      = 2,
  parameter int MAX_STALL = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [NSRC*REG_AW-1:0]         id_src_idx,
  input  logic [NSRC-1:0]                id_src_used,
  input  logic [NSRC*LANES*DATA_W-1:0]   id_src_data,
  input  logic                           ex_we,
  input  logic                           mem_we,
  input  logic                           wb_we,
  input  logic [REG_AW-1:0]              ex_dest,
  input  logic [REG_AW-1:0]              mem_dest,
  input  logic [REG_AW-1:0]              wb_dest,
  input  logic                           ex_ok,
  input  logic                           mem_ok,
  input  logic [LANES*DATA_W-1:0]        ex_data,
  input  logic [LANES*DATA_W-1:0]        mem_data,
  input  logic [LANES*DATA_W-1:0]        wb_data,
  input  logic                           flush,
  output logic                           stall,
  output logic                           op_valid,
  output logic [NSRC*LANES*DATA_W-1:0]   op_data,
  output logic [NSRC*2-1:0]              op_sel,
  output logic [15:0]                    stall_cycles,
  output logic                           stall_timeout
);

  localparam int OW  = LANES * DATA_W;
  localparam int RCW = $clog2(MAX_STALL + 1);
  localparam logic [RCW-1:0] RUN_MAX = RCW'(MAX_STALL);

  logic [NSRC-1:0][OW-1:0] sel_data;
  logic [NSRC-1:0][1:0]    sel_bits;
  logic [NSRC-1:0]         hazard;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    fwd_src_select #(.REG_AW(REG_AW), .OW(OW)) u_sel (
      .idx      (id_src_idx[k*REG_AW +: REG_AW]),
      .used     (id_src_used[k]),
      .rf_data  (id_src_data[k*OW +: OW]),
      .ex_we    (ex_we),
      .ex_dest  (ex_dest),
      .ex_ok    (ex_ok),
      .ex_data  (ex_data),
      .mem_we   (mem_we),
      .mem_dest (mem_dest),
      .mem_ok   (mem_ok),
      .mem_data (mem_data),
      .wb_we    (wb_we),
      .wb_dest  (wb_dest),
      .wb_data  (wb_data),
      .data     (sel_data[k]),
      .sel      (sel_bits[k]),
      .hazard   (hazard[k])
    );
  end

  // Purely a function of this cycle's ID/stage inputs; flush overrides.
  assign stall = id_valid && (|hazard) && !flush;

  fwd_state_t     state;
  logic [RCW-1:0] run_cnt, cnt_nxt;

  // Length of the current stall run including this cycle; a run starts
  // fresh whenever we are coming from RUN.
  always_comb begin
    cnt_nxt = '0;
    if (stall) begin
      if (state == RUN)             cnt_nxt = RCW'(1);
      else if (run_cnt != RUN_MAX)  cnt_nxt = run_cnt + RCW'(1);
      else                          cnt_nxt = run_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      run_cnt       <= '0;
      stall_timeout <= 1'b0;
      stall_cycles  <= '0;
      op_valid      <= 1'b0;
      op_data       <= '0;
      op_sel        <= '0;
    end else begin
      state   <= (flush || !stall) ? RUN : STALL;
      run_cnt <= cnt_nxt;
      if (stall && cnt_nxt == RUN_MAX) stall_timeout <= 1'b1;
      if (stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;

      if (flush || stall) begin
        // Bubble into EX; operand register keeps its last contents.
        op_valid <= 1'b0;
      end else begin
        op_valid <= id_valid;
        op_data  <= sel_data;
        op_sel   <= sel_bits;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int DW = 32, LN = 4, AW = 4, NS = 3, MS = 3;
  localparam int OW = DW * LN;

  logic                clk = 1'b0;
  logic                rst;
  logic                id_valid;
  logic [NS*AW-1:0]    id_src_idx;
  logic [NS-1:0]       id_src_used;
  logic [NS*OW-1:0]    id_src_data;
  logic                ex_we, mem_we, wb_we;
  logic [AW-1:0]       ex_dest, mem_dest, wb_dest;
  logic                ex_ok, mem_ok;
  logic [OW-1:0]       ex_data, mem_data, wb_data;
  logic                flush;
  logic                stall;
  logic                op_valid;
  logic [NS*OW-1:0]    op_data;
  logic [NS*2-1:0]     op_sel;
  logic [15:0]         stall_cycles;
  logic                stall_timeout;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [OW-1:0] R0 = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
  localparam logic [OW-1:0] R1 = 128'hFEDC_BA98_7654_3210_1111_2222_3333_4444;
  localparam logic [OW-1:0] R2 = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
  localparam logic [OW-1:0] WV = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;

  fwd_hazard_unit #(
    .DATA_W(DW), .LANES(LN), .REG_AW(AW), .NSRC(NS), .MAX_STALL(MS)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_idx(id_src_idx),
    .id_src_used(id_src_used), .id_src_data(id_src_data),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
    .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .ex_ok(ex_ok), .mem_ok(mem_ok),
    .ex_data(ex_data), .mem_data(mem_data), .wb_data(wb_data),
    .flush(flush), .stall(stall), .op_valid(op_valid), .op_data(op_data),
    .op_sel(op_sel), .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int k, input logic [AW-1:0] idx, input logic used,
                         input logic [OW-1:0] d);
    id_src_idx[k*AW +: AW]  = idx;
    id_src_used[k]          = used;
    id_src_data[k*OW +: OW] = d;
  endtask

  task automatic clr;
    id_valid = 0; id_src_idx = '0; id_src_used = '0; id_src_data = '0;
    ex_we = 0; mem_we = 0; wb_we = 0; ex_dest = '0; mem_dest = '0; wb_dest = '0;
    ex_ok = 1; mem_ok = 1; ex_data = '0; mem_data = '0; wb_data = '0; flush = 0;
  endtask

  function automatic logic [OW-1:0] opk(input int k);
    return op_data[k*OW +: OW];
  endfunction

  initial begin
    rst = 1; clr();
    tick(); tick();
    chk("rst op_valid", OW'(op_valid), '0);
    chk("rst op_data", OW'(|op_data), '0);
    chk("rst op_sel", OW'(op_sel), '0);
    chk("rst stall_cycles", OW'(stall_cycles), '0);
    chk("rst timeout", OW'(stall_timeout), '0);
    rst = 0;

    // EX beats MEM for the same register
    id_valid = 1;
    set_src(0, 4'd3, 1, 128'h1111);
    ex_we = 1; ex_dest = 4'd3; ex_ok = 1; ex_data = 128'hAAAA;
    mem_we = 1; mem_dest = 4'd3; mem_ok = 1; mem_data = 128'hBBBB;
    #1 chk("ex prio stall", OW'(stall), '0);
    tick();
    chk("ex prio op_valid", OW'(op_valid), 1);
    chk("ex prio op0", opk(0), 128'hAAAA);
    chk("ex prio sel0", OW'(op_sel[1:0]), 3);

    // r0 never forwarded (even not-ready EX); MEM beats WB; no match -> RF
    set_src(0, 4'd0, 1, '0);
    ex_dest = 4'd0; ex_ok = 0; ex_data = 128'h1234;
    set_src(1, 4'd2, 1, 128'h2222);
    mem_dest = 4'd2; mem_data = 128'h5555;
    wb_we = 1; wb_dest = 4'd2; wb_data = 128'h6666;
    set_src(2, 4'd7, 1, 128'h7777);
    #1 chk("r0 stall", OW'(stall), '0);
    tick();
    chk("r0 op0", opk(0), '0);
    chk("mem prio op1", opk(1), 128'h5555);
    chk("rf op2", opk(2), 128'h7777);
    chk("mix op_sel", OW'(op_sel), OW'(6'b00_10_00));

    // WB match on source 2 only; unused source ignores a not-ready EX match
    clr(); id_valid = 1;
    ex_we = 1; ex_dest = 4'd4; ex_ok = 0; ex_data = 128'hEEEE;
    set_src(0, 4'd4, 0, R0);
    set_src(1, 4'd5, 1, R1);
    set_src(2, 4'd9, 1, R2);
    wb_we = 1; wb_dest = 4'd9; wb_data = WV;
    #1 chk("wb stall", OW'(stall), '0);
    tick();
    chk("wb op0", opk(0), R0);
    chk("wb op1", opk(1), R1);
    chk("wb op2", opk(2), WV);
    chk("wb op_sel", OW'(op_sel), OW'(6'b01_00_00));

    // Load-use: EX not ready for two cycles, then result in MEM
    clr(); id_valid = 1;
    set_src(0, 4'd5, 1, 128'h5050);
    ex_we = 1; ex_dest = 4'd5; ex_ok = 0;
    #1 chk("lu stall1", OW'(stall), 1);
    tick();
    chk("lu bubble1", OW'(op_valid), 0);
    chk("lu hold op0", opk(0), R0);
    chk("lu stall2", OW'(stall), 1);
    tick();
    chk("lu bubble2", OW'(op_valid), 0);
    ex_we = 0; mem_we = 1; mem_dest = 4'd5; mem_ok = 1; mem_data = 128'h77;
    #1 chk("lu release", OW'(stall), 0);
    tick();
    chk("lu op_valid", OW'(op_valid), 1);
    chk("lu op0", opk(0), 128'h77);
    chk("lu sel0", OW'(op_sel[1:0]), 2);
    chk("lu stall_cycles", OW'(stall_cycles), 2);
    chk("lu timeout", OW'(stall_timeout), 0);

    // Two stalls, flush (restarts the run), then five more stalls
    mem_we = 0; ex_we = 1; ex_dest = 4'd5; ex_ok = 0;
    tick(); tick();
    chk("pre flush cycles", OW'(stall_cycles), 4);
    flush = 1;
    #1 chk("flush stall", OW'(stall), 0);
    tick();
    chk("flush bubble", OW'(op_valid), 0);
    chk("flush cycles", OW'(stall_cycles), 4);
    flush = 0;
    tick();
    chk("run1 timeout", OW'(stall_timeout), 0);
    tick();
    chk("run2 timeout", OW'(stall_timeout), 0);
    tick();
    chk("run3 timeout", OW'(stall_timeout), 1);
    tick(); tick();
    chk("run5 stall", OW'(stall), 1);
    chk("run5 cycles", OW'(stall_cycles), 9);
    ex_we = 0;
    #1 chk("clear stall", OW'(stall), 0);
    tick();
    chk("clear op_valid", OW'(op_valid), 1);
    chk("clear op0", opk(0), 128'h5050);
    chk("sticky timeout", OW'(stall_timeout), 1);

    // No instruction in ID: hazard does not stall
    id_valid = 0; ex_we = 1; ex_ok = 0;
    #1 chk("idle stall", OW'(stall), 0);
    tick();
    chk("idle op_valid", OW'(op_valid), 0);
    chk("idle cycles", OW'(stall_cycles), 9);

    // Reset in the middle of a stall
    id_valid = 1;
    tick();
    chk("mid cycles", OW'(stall_cycles), 10);
    rst = 1;
    tick();
    chk("mid rst op_valid", OW'(op_valid), 0);
    chk("mid rst op_data", OW'(|op_data), 0);
    chk("mid rst op_sel", OW'(op_sel), 0);
    chk("mid rst cycles", OW'(stall_cycles), 0);
    chk("mid rst timeout", OW'(stall_timeout), 0);
    rst = 0; clr();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
